// File: rtl/pu_pkg.sv
// pu_pkg: shared constants, FSM state and lane payload for the PU feeder.
package pu_pkg;

  localparam int unsigned DATA_W    = 5;
  localparam int unsigned LANES     = 4;
  localparam int unsigned PU_LAT    = 2;
  localparam int unsigned RES_W     = 12;
  localparam int unsigned LANE_W    = $clog2(LANES);
  localparam int unsigned VEC_CNT_W = 16;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } feeder_state_e;

  // One (input, weight) operand pair as presented to a PU lane.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] weight;
  } pu_beat_t;

endpackage

// File: rtl/pu_valid_pipe.sv
// pu_valid_pipe: DEPTH-stage shift register carrying {valid, last} alongside
// the PU's internal register stages.
module pu_valid_pipe
  import pu_pkg::*;
#(
  parameter int unsigned DEPTH = PU_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;

  // Advance one stage per cycle; a last tag only travels with a valid.
  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    valid_d[0] = in_valid;
    last_d[0]  = in_valid & in_last;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  // Stage registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/pu_feeder.sv
// pu_feeder: packs streamed (input, weight) beats into 4-lane vectors, issues
// each vector to the PU for one cycle and tags the returning result.
// Optional: define PU_FEEDER_VEC_COUNT_EN to add the 16-bit vec_count output.
module pu_feeder
  import pu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [DATA_W-1:0]    in_weight,
  input  logic                 in_last,
  output logic [DATA_W-1:0]    pu_input1,
  output logic [DATA_W-1:0]    pu_input2,
  output logic [DATA_W-1:0]    pu_input3,
  output logic [DATA_W-1:0]    pu_input4,
  output logic [DATA_W-1:0]    pu_weight1,
  output logic [DATA_W-1:0]    pu_weight2,
  output logic [DATA_W-1:0]    pu_weight3,
  output logic [DATA_W-1:0]    pu_weight4,
  input  logic [RES_W-1:0]     pu_result,
`ifdef PU_FEEDER_VEC_COUNT_EN
  output logic [VEC_CNT_W-1:0] vec_count,
`endif
  output logic                 out_valid,
  output logic [RES_W-1:0]     out_data,
  output logic                 out_last
);

  feeder_state_e          state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  pu_beat_t [LANES-1:0]   stage_q, stage_d;
  pu_beat_t [LANES-1:0]   issue_q, issue_d;
  logic                   issue_valid_q, issue_valid_d;
  logic                   issue_last_q, issue_last_d;
  logic                   in_ready_q, in_ready_d;
  logic                   accept;
  logic                   complete;
  logic                   pipe_valid;
  logic                   pipe_last;

  // Lane packing, one-cycle issue and FILL/DRAIN sequencing.
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    stage_d       = stage_q;
    issue_d       = '0;
    issue_valid_d = 1'b0;
    issue_last_d  = 1'b0;
    accept        = in_valid && in_ready_q;
    complete      = accept && (in_last || (lane_q == LANE_W'(LANES - 1)));

    if (complete) begin
      // Staging above the current lane is already zero, so short vectors pad with 0.
      issue_d         = stage_q;
      issue_d[lane_q] = '{data: in_data, weight: in_weight};
      issue_valid_d   = 1'b1;
      issue_last_d    = in_last;
      stage_d         = '0;
      lane_d          = '0;
    end else if (accept) begin
      stage_d[lane_q] = '{data: in_data, weight: in_weight};
      lane_d          = lane_q + LANE_W'(1);
    end

    case (state_q)
      FILL:    if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (pipe_valid && pipe_last) state_d = FILL;
      default: state_d = FILL;
    endcase

    in_ready_d = (state_d == FILL);
  end

  // State, staging and issue registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= FILL;
      lane_q        <= '0;
      stage_q       <= '0;
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_last_q  <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      stage_q       <= stage_d;
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      issue_last_q  <= issue_last_d;
      in_ready_q    <= in_ready_d;
    end
  end

  pu_valid_pipe #(
    .DEPTH (PU_LAT)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid_q),
    .in_last   (issue_last_q),
    .out_valid (pipe_valid),
    .out_last  (pipe_last)
  );

`ifdef PU_FEEDER_VEC_COUNT_EN
  logic [VEC_CNT_W-1:0] vec_count_q, vec_count_d;

  // Delivered-result counter; wraps at full scale.
  always_comb begin
    vec_count_d = vec_count_q + VEC_CNT_W'(pipe_valid);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) vec_count_q <= '0;
    else      vec_count_q <= vec_count_d;
  end

  assign vec_count = vec_count_q;
`endif

  assign in_ready   = in_ready_q;
  assign pu_input1  = issue_q[0].data;
  assign pu_input2  = issue_q[1].data;
  assign pu_input3  = issue_q[2].data;
  assign pu_input4  = issue_q[3].data;
  assign pu_weight1 = issue_q[0].weight;
  assign pu_weight2 = issue_q[1].weight;
  assign pu_weight3 = issue_q[2].weight;
  assign pu_weight4 = issue_q[3].weight;
  assign out_valid  = pipe_valid;
  assign out_last   = pipe_last;
  assign out_data   = pipe_valid ? pu_result : '0;

endmodule

// File: tb/tb_pu_feeder.sv
// tb_pu_feeder: table-driven vectors plus hand-written corner sequences, with a
// behavioural 2-stage PU in the loop and a scoreboard of expected results.
module tb_pu_feeder;

  localparam int unsigned DW = 5;
  localparam int unsigned RW = 12;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data   = '0;
  logic [DW-1:0] in_weight = '0;
  logic          in_last   = 1'b0;
  logic [DW-1:0] pu_input1, pu_input2, pu_input3, pu_input4;
  logic [DW-1:0] pu_weight1, pu_weight2, pu_weight3, pu_weight4;
  logic [RW-1:0] pu_result;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          out_last;
`ifdef PU_FEEDER_VEC_COUNT_EN
  logic [15:0]   vec_count;
`endif

  always #5 clk = ~clk;

  pu_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_weight  (in_weight),
    .in_last    (in_last),
    .pu_input1  (pu_input1),
    .pu_input2  (pu_input2),
    .pu_input3  (pu_input3),
    .pu_input4  (pu_input4),
    .pu_weight1 (pu_weight1),
    .pu_weight2 (pu_weight2),
    .pu_weight3 (pu_weight3),
    .pu_weight4 (pu_weight4),
    .pu_result  (pu_result),
`ifdef PU_FEEDER_VEC_COUNT_EN
    .vec_count  (vec_count),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  // Behavioural PU: product-sum register then result register, sharing rst.
  logic [RW-1:0] pu_sum_q = '0;
  logic [RW-1:0] pu_res_q = '0;
  always @(posedge clk) begin
    if (!rst) begin
      pu_sum_q <= '0;
      pu_res_q <= '0;
    end else begin
      pu_sum_q <= RW'(pu_input1) * RW'(pu_weight1) + RW'(pu_input2) * RW'(pu_weight2)
                + RW'(pu_input3) * RW'(pu_weight3) + RW'(pu_input4) * RW'(pu_weight4);
      pu_res_q <= pu_sum_q;
    end
  end
  assign pu_result = pu_res_q;

  logic [3:0][DW-1:0] p_in;
  logic [3:0][DW-1:0] p_wt;
  assign p_in = {pu_input4, pu_input3, pu_input2, pu_input1};
  assign p_wt = {pu_weight4, pu_weight3, pu_weight2, pu_weight1};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int   res;
    logic last;
    int   due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    int                 n;
    logic [3:0][DW-1:0] d;
    logic [3:0][DW-1:0] w;
    int                 res;
  } rec_t;
  rec_t tbl[6];

  function automatic rec_t mk(input int n, input int d0, input int d1, input int d2,
                              input int d3, input int w0, input int w1, input int w2,
                              input int w3, input int res);
    rec_t r;
    r.n    = n;
    r.d[0] = DW'(d0); r.d[1] = DW'(d1); r.d[2] = DW'(d2); r.d[3] = DW'(d3);
    r.w[0] = DW'(w0); r.w[1] = DW'(w1); r.w[2] = DW'(w2); r.w[3] = DW'(w3);
    r.res  = res;
    return r;
  endfunction

  // Result monitor: every out_valid pops one expectation, checking value, tag and cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: got out_data=%0d expected no result (cycle %0d)",
                   out_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", int'(out_data), mon_e.res);
          chk("out_last", int'(out_last), int'(mon_e.last));
          chk("out_cycle", cyc, mon_e.due);
        end
      end else begin
        chk("out_data_idle", int'(out_data), 0);
      end
    end
  end

  // Drive one beat at a negedge; optionally queue the vector result it completes.
  task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] w, input logic last,
                           input logic push, input int exp, input logic strict);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (strict || waited == 20) chk("in_ready_beat", int'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_weight = w;
    in_last   = last;
    if (push) sb.push_back('{res: exp, last: last, due: cyc + 3});
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    in_last   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain_sb();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got %0d results missing expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = mk(4, 1, 2, 3, 4, 1, 2, 3, 4, 30);
    tbl[1] = mk(4, 31, 31, 31, 31, 31, 31, 31, 31, 3844);
    tbl[2] = mk(2, 2, 4, 0, 0, 3, 5, 0, 0, 26);
    tbl[3] = mk(1, 5, 0, 0, 0, 6, 0, 0, 0, 30);
    tbl[4] = mk(3, 1, 3, 5, 0, 2, 4, 6, 0, 44);
    tbl[5] = mk(4, 10, 0, 7, 31, 3, 31, 7, 1, 110);

    // Power-on reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_pu_input1", int'(pu_input1), 0);
    chk("rst_pu_weight4", int'(pu_weight4), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);

    // Table-driven vectors, each ending in in_last and a full drain
    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < tbl[r].n; b++)
        send_beat(tbl[r].d[b], tbl[r].w[b], b == tbl[r].n - 1, b == tbl[r].n - 1,
                  tbl[r].res, 1'b1);
      for (int l = 0; l < 4; l++) begin
        chk("issue_input", int'(p_in[l]), int'(tbl[r].d[l]));
        chk("issue_weight", int'(p_wt[l]), int'(tbl[r].w[l]));
      end
      chk("drain_rdy", int'(in_ready), 0);
      @(negedge clk);
      chk("pu_idle_input1", int'(pu_input1), 0);
      chk("pu_idle_weight1", int'(pu_weight1), 0);
      chk("drain_rdy", int'(in_ready), 0);
      @(negedge clk);
      chk("drain_rdy", int'(in_ready), 0);
      @(negedge clk);
      chk("rdy_after_drain", int'(in_ready), 1);
    end
    drain_sb();

    // Back-to-back: two full vectors with no bubble, results 4 cycles apart
    for (int b = 0; b < 8; b++)
      send_beat(5'd1, 5'd1, 1'b0, (b == 3) || (b == 7), 4, 1'b1);
    chk("b2b_rdy", int'(in_ready), 1);
    drain_sb();
    repeat (2) @(negedge clk);

    // Reset mid-fill: partial (7,7) beats must vanish
    send_beat(5'd7, 5'd7, 1'b0, 1'b0, 0, 1'b1);
    send_beat(5'd7, 5'd7, 1'b0, 1'b0, 0, 1'b1);
    do_reset();
    chk("midfill_rst_rdy", int'(in_ready), 0);
    chk("midfill_rst_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("midfill_rel_rdy", int'(in_ready), 1);
    for (int b = 0; b < 4; b++)
      send_beat(5'd1, 5'd1, b == 3, b == 3, 4, 1'b1);
    drain_sb();
    @(negedge clk);
    chk("midfill_rdy_after", int'(in_ready), 1);

    // Reset mid-flight: an issued vector must never produce out_valid
    for (int b = 0; b < 4; b++)
      send_beat(5'd3, 5'd3, 1'b0, 1'b0, 0, 1'b1);
    do_reset();
    chk("flight_rst_pu_input1", int'(pu_input1), 0);
    chk("flight_rst_rdy", int'(in_ready), 0);
    repeat (5) @(negedge clk);
    chk("flight_rdy_after", int'(in_ready), 1);

`ifdef PU_FEEDER_VEC_COUNT_EN
    // Vector counter: three results, then cleared by reset
    do_reset();
    @(negedge clk);
    chk("vec_count_rst", int'(vec_count), 0);
    for (int v = 0; v < 3; v++)
      for (int b = 0; b < 4; b++)
        send_beat(5'd1, 5'd1, 1'b0, b == 3, 4, 1'b1);
    drain_sb();
    @(negedge clk);
    chk("vec_count_3", int'(vec_count), 3);
    do_reset();
    chk("vec_count_clr", int'(vec_count), 0);
    @(negedge clk);
`endif

    drain_sb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
